// File: rtl/uart_cmd_parser.sv
// Framed command parser: A5, b0[15:8], b0[7:0], b1[15:8], b1[7:0], vr, sum, F7.
// A good frame commits b0/b1/vr together; bad or stalled frames raise one-cycle error pulses.
module uart_cmd_parser #(
  parameter int unsigned TOUT   = 40000,
  parameter logic [15:0] B0_RST = 16'd0,
  parameter logic [15:0] B1_RST = 16'd0,
  parameter logic [7:0]  VR_RST = 8'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_stb,
  output logic [15:0] b0,
  output logic [15:0] b1,
  output logic [7:0]  vr,
  output logic        upd,
  output logic        err_chk,
  output logic        err_frm,
  output logic        busy,
  output logic [7:0]  frm_cnt
);

  localparam logic [7:0]  HDR   = 8'hA5;
  localparam logic [7:0]  TRM   = 8'hF7;
  localparam logic [15:0] T_LIM = 16'(TOUT - 1);

  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, TERM} state_t;

  state_t      state;
  logic [2:0]  idx;
  logic [7:0]  sum;
  logic [15:0] tmr;
  logic [15:0] sh_b0;
  logic [15:0] sh_b1;
  logic [7:0]  sh_vr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      sum     <= '0;
      tmr     <= '0;
      sh_b0   <= '0;
      sh_b1   <= '0;
      sh_vr   <= '0;
      b0      <= B0_RST;
      b1      <= B1_RST;
      vr      <= VR_RST;
      upd     <= 1'b0;
      err_chk <= 1'b0;
      err_frm <= 1'b0;
      busy    <= 1'b0;
      frm_cnt <= '0;
    end else begin
      upd     <= 1'b0;
      err_chk <= 1'b0;
      err_frm <= 1'b0;
      if (rx_stb) begin
        // An arriving byte always takes precedence over a coincident timeout.
        tmr <= '0;
        unique case (state)
          IDLE: begin
            if (rx_data == HDR) begin
              state <= PAYLOAD;
              idx   <= '0;
              sum   <= '0;
              busy  <= 1'b1;
            end
          end
          PAYLOAD: begin
            sum <= sum + rx_data;
            unique case (idx)
              3'd0:    sh_b0[15:8] <= rx_data;
              3'd1:    sh_b0[7:0]  <= rx_data;
              3'd2:    sh_b1[15:8] <= rx_data;
              3'd3:    sh_b1[7:0]  <= rx_data;
              default: sh_vr       <= rx_data;
            endcase
            if (idx == 3'd4) state <= CHECK;
            else             idx   <= idx + 3'd1;
          end
          CHECK: begin
            if (rx_data == sum) begin
              state <= TERM;
            end else begin
              err_chk <= 1'b1;
              state   <= IDLE;
              busy    <= 1'b0;
            end
          end
          TERM: begin
            if (rx_data == TRM) begin
              b0      <= sh_b0;
              b1      <= sh_b1;
              vr      <= sh_vr;
              upd     <= 1'b1;
              frm_cnt <= frm_cnt + 8'd1;
              state   <= IDLE;
              busy    <= 1'b0;
            end else if (rx_data == HDR) begin
              // A header in the terminator slot starts a fresh frame.
              err_frm <= 1'b1;
              state   <= PAYLOAD;
              idx     <= '0;
              sum     <= '0;
            end else begin
              err_frm <= 1'b1;
              state   <= IDLE;
              busy    <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end else if (state != IDLE) begin
        if (tmr == T_LIM) begin
          err_frm <= 1'b1;
          state   <= IDLE;
          busy    <= 1'b0;
          tmr     <= '0;
        end else begin
          tmr <= tmr + 16'd1;
        end
      end else begin
        tmr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: a per-byte expectation table plus
// hand-written timeout, reset and 256-frame wrap sequences.
module tb_uart_cmd_parser;

  localparam int unsigned TOUT = 400;
  localparam logic [15:0] RB0 = 16'h1234;
  localparam logic [15:0] RB1 = 16'h5678;
  localparam logic [7:0]  RVR = 8'h9A;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_stb = 1'b0;
  logic [15:0] b0, b1;
  logic [7:0]  vr, frm_cnt;
  logic        upd, err_chk, err_frm, busy;

  uart_cmd_parser #(.TOUT(TOUT), .B0_RST(RB0), .B1_RST(RB1), .VR_RST(RVR)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_stb(rx_stb),
    .b0(b0), .b1(b1), .vr(vr), .upd(upd), .err_chk(err_chk),
    .err_frm(err_frm), .busy(busy), .frm_cnt(frm_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int upd_n = 0;
  int err_n = 0;

  always @(negedge clk) begin
    if (upd) upd_n++;
    if (err_chk || err_frm) err_n++;
  end

  // flags are {upd, err_chk, err_frm, busy}
  typedef struct {
    logic [7:0]  d;
    int          gap;
    logic [3:0]  fl;
    logic [15:0] b0;
    logic [15:0] b1;
    logic [7:0]  vr;
    logic [7:0]  cnt;
  } vec_t;

  vec_t        vq[$];
  logic [15:0] cb0 = RB0;
  logic [15:0] cb1 = RB1;
  logic [7:0]  cvr = RVR;
  logic [7:0]  ccnt = 8'd0;

  task automatic add(input logic [7:0] d, input int gap, input logic [3:0] fl);
    vec_t v;
    v.d = d; v.gap = gap; v.fl = fl;
    v.b0 = cb0; v.b1 = cb1; v.vr = cvr; v.cnt = ccnt;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic ok, input string detail);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  task automatic send(input logic [7:0] d, input int gap);
    repeat (gap) @(negedge clk) rx_stb = 1'b0;
    @(negedge clk);
    rx_stb  = 1'b1;
    rx_data = d;
    @(posedge clk);
    #1;
  endtask

  function automatic string state_str();
    return $sformatf("fl=%b b0=%h b1=%h vr=%h cnt=%h",
                     {upd, err_chk, err_frm, busy}, b0, b1, vr, frm_cnt);
  endfunction

  logic [7:0] frm[8];
  logic [7:0] s;
  int         u0, e0, hit, bad;

  initial begin
    // ---------------- table ----------------
    add(8'hA5, 125, 4'b0001);
    add(8'h00, 125, 4'b0001);
    add(8'h14, 125, 4'b0001);
    add(8'h00, 125, 4'b0001);
    add(8'h05, 125, 4'b0001);
    add(8'h50, 125, 4'b0001);
    add(8'h69, 125, 4'b0001);
    cb0 = 16'h0014; cb1 = 16'h0005; cvr = 8'h50; ccnt = 8'd1;
    add(8'hF7, 125, 4'b1000);
    add(8'h11, 2, 4'b0000);
    // checksum off by one, trailing F7 ignored
    add(8'hA5, 3, 4'b0001);
    add(8'h00, 3, 4'b0001);
    add(8'h14, 3, 4'b0001);
    add(8'h00, 3, 4'b0001);
    add(8'h05, 3, 4'b0001);
    add(8'h50, 3, 4'b0001);
    add(8'h6A, 3, 4'b0100);
    add(8'hF7, 3, 4'b0000);
    // byte lands on the same edge the timer expires
    add(8'hA5, 2, 4'b0001);
    add(8'h01, TOUT - 1, 4'b0001);
    add(8'h02, 1, 4'b0001);
    add(8'h03, 1, 4'b0001);
    add(8'h04, 1, 4'b0001);
    add(8'h05, 1, 4'b0001);
    add(8'h0F, 1, 4'b0001);
    cb0 = 16'h0102; cb1 = 16'h0304; cvr = 8'h05; ccnt = 8'd2;
    add(8'hF7, 1, 4'b1000);
    // header in terminator slot resyncs
    add(8'hA5, 0, 4'b0001);
    add(8'h01, 0, 4'b0001);
    add(8'h02, 0, 4'b0001);
    add(8'h03, 0, 4'b0001);
    add(8'h04, 0, 4'b0001);
    add(8'h05, 0, 4'b0001);
    add(8'h0F, 0, 4'b0001);
    add(8'hA5, 0, 4'b0011);
    add(8'h00, 0, 4'b0001);
    add(8'h01, 0, 4'b0001);
    add(8'h00, 0, 4'b0001);
    add(8'h02, 0, 4'b0001);
    add(8'h03, 0, 4'b0001);
    add(8'h06, 0, 4'b0001);
    cb0 = 16'h0001; cb1 = 16'h0002; cvr = 8'h03; ccnt = 8'd3;
    add(8'hF7, 0, 4'b1000);
    // A5/F7 as payload values
    add(8'hA5, 1, 4'b0001);
    add(8'hA5, 1, 4'b0001);
    add(8'hF7, 1, 4'b0001);
    add(8'hF7, 1, 4'b0001);
    add(8'hA5, 1, 4'b0001);
    add(8'h01, 1, 4'b0001);
    add(8'h39, 1, 4'b0001);
    cb0 = 16'hA5F7; cb1 = 16'hF7A5; cvr = 8'h01; ccnt = 8'd4;
    add(8'hF7, 1, 4'b1000);
    // bad terminator
    add(8'hA5, 1, 4'b0001);
    for (int i = 0; i < 6; i++) add(8'h00, 1, 4'b0001);
    add(8'h33, 1, 4'b0010);
    // mismatching A5 in checksum slot is not a header
    add(8'hA5, 1, 4'b0001);
    add(8'h00, 1, 4'b0001);
    add(8'h00, 1, 4'b0001);
    add(8'h00, 1, 4'b0001);
    add(8'h00, 1, 4'b0001);
    add(8'h01, 1, 4'b0001);
    add(8'hA5, 1, 4'b0100);
    add(8'h00, 0, 4'b0000);

    // ---------------- reset state ----------------
    #12;
    check("reset_vals", b0 == RB0 && b1 == RB1 && vr == RVR && frm_cnt == 8'd0 &&
          {upd, err_chk, err_frm, busy} == 4'b0000,
          $sformatf("got %s exp b0=%h b1=%h vr=%h cnt=00 fl=0000", state_str(), RB0, RB1, RVR));
    @(negedge clk) rst = 1'b0;

    foreach (vq[i]) begin
      send(vq[i].d, vq[i].gap);
      check($sformatf("vec%0d", i),
            {upd, err_chk, err_frm, busy} == vq[i].fl && b0 == vq[i].b0 && b1 == vq[i].b1 &&
            vr == vq[i].vr && frm_cnt == vq[i].cnt,
            $sformatf("got %s exp fl=%b b0=%h b1=%h vr=%h cnt=%h", state_str(),
                      vq[i].fl, vq[i].b0, vq[i].b1, vq[i].vr, vq[i].cnt));
    end

    // ---------------- inter-byte timeout ----------------
    send(8'hA5, 2);
    send(8'h00, 1);
    send(8'h00, 1);
    send(8'h00, 1);
    @(negedge clk) rx_stb = 1'b0;
    hit = 0; bad = 0;
    for (int k = 1; k <= int'(TOUT) + 2; k++) begin
      @(posedge clk);
      #1;
      if (k < int'(TOUT)) begin
        if (err_frm || !busy) bad++;
      end else if (k == int'(TOUT)) begin
        if (err_frm && !busy) hit = 1;
      end else begin
        if (err_frm || busy) bad++;
      end
    end
    check("timeout_exact", hit == 1, $sformatf("got pulse_at_TOUT=%0d exp 1", hit));
    check("timeout_clean", bad == 0, $sformatf("got %0d off-cycle faults exp 0", bad));
    check("timeout_hold", b0 == 16'hA5F7 && b1 == 16'hF7A5 && vr == 8'h01 && frm_cnt == 8'd4,
          $sformatf("got %s exp b0=a5f7 b1=f7a5 vr=01 cnt=04", state_str()));

    // ---------------- reset mid-frame ----------------
    frm = '{8'hA5, 8'h00, 8'h14, 8'h00, 8'h05, 8'h50, 8'h69, 8'hF7};
    for (int i = 0; i < 4; i++) send(frm[i], 1);
    e0 = err_n;
    @(negedge clk);
    rx_stb = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_vals", b0 == RB0 && b1 == RB1 && vr == RVR && frm_cnt == 8'd0 &&
          {upd, err_chk, err_frm, busy} == 4'b0000,
          $sformatf("got %s exp reset values", state_str()));
    @(negedge clk) rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      send(frm[i], 1);
      if (b0 != RB0 || b1 != RB1 || vr != RVR || frm_cnt != 8'd0 || upd) bad++;
    end
    check("midrst_hold", bad == 0, $sformatf("got %0d early changes exp 0", bad));
    send(frm[7], 1);
    check("midrst_commit", upd && b0 == 16'h0014 && b1 == 16'h0005 && vr == 8'h50 && frm_cnt == 8'd1,
          $sformatf("got %s exp upd b0=0014 b1=0005 vr=50 cnt=01", state_str()));
    @(negedge clk) rx_stb = 1'b0;
    @(posedge clk);
    #1;
    check("upd_width", upd == 1'b0, $sformatf("got upd=%b exp 0", upd));
    check("midrst_noerr", err_n == e0, $sformatf("got %0d err pulses exp 0", err_n - e0));

    // ---------------- 256 back-to-back frames ----------------
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    u0 = upd_n; e0 = err_n;
    for (int f = 0; f < 256; f++) begin
      frm[0] = 8'hA5;
      frm[1] = 8'(f);
      frm[2] = ~8'(f);
      frm[3] = 8'(f) ^ 8'h55;
      frm[4] = 8'(f);
      frm[5] = 8'(f + 1);
      s = 8'h00;
      for (int j = 1; j < 6; j++) s = s + frm[j];
      frm[6] = s;
      frm[7] = 8'hF7;
      for (int j = 0; j < 8; j++) send(frm[j], 0);
    end
    @(negedge clk) rx_stb = 1'b0;
    @(posedge clk);
    #1;
    check("wrap_upd", upd_n - u0 == 256, $sformatf("got %0d upd pulses exp 256", upd_n - u0));
    check("wrap_noerr", err_n == e0, $sformatf("got %0d err pulses exp 0", err_n - e0));
    check("wrap_cnt", frm_cnt == 8'd0, $sformatf("got cnt=%h exp 00", frm_cnt));
    check("wrap_last", b0 == 16'hFF00 && b1 == 16'hAAFF && vr == 8'h00,
          $sformatf("got %s exp b0=ff00 b1=aaff vr=00", state_str()));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
